// File: rtl/psram_pkg.sv
// Shared PSRAM definitions: operand encodings, arbiter state set and the QPI
// command bytes, so the PSRAM driver and the arbiter agree on one source.
package psram_pkg;

  localparam logic [1:0] RW_NONE  = 2'd0;
  localparam logic [1:0] RW_WRITE = 2'd1;
  localparam logic [1:0] RW_READ  = 2'd2;

  typedef enum logic [2:0] {
    ST_WAIT_INIT,
    ST_IDLE,
    ST_ISSUE,
    ST_BUSY,
    ST_GAP
  } arb_state_t;

  localparam logic [7:0] CMD_READ_QUAD  = 8'hEB;
  localparam logic [7:0] CMD_WRITE_QUAD = 8'h38;
  localparam logic [7:0] CMD_RESET_EN   = 8'h66;
  localparam logic [7:0] CMD_RESET      = 8'h99;
  localparam logic [7:0] CMD_ENTER_QPI  = 8'h35;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin picker: a lone request wins outright,
// a tie goes to the port that was not served last.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_valid,
  output logic       gnt_id
);

  always_comb begin
    gnt_valid = |req;
    gnt_id    = (req == 2'b11) ? ~last : req[1];
  end

endmodule

// File: rtl/psram_arbiter.sv
// Two-port arbiter and single-transaction sequencer in front of the QPI PSRAM
// top: init gating, round-robin grant, guarded completion, timeout and gap.
module psram_arbiter
  import psram_pkg::*;
#(
  parameter int GUARD   = 3,
  parameter int GAP     = 2,
  parameter int TIMEOUT = 63
) (
  input  logic        mem_clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [23:0] addr0,
  input  logic [23:0] addr1,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic        err,
  output logic [15:0] rdata,
  output logic        busy,
  input  logic        mem_qpi_on,
  input  logic        mem_endcommand,
  input  logic [15:0] mem_data_out,
  output logic        mem_quad_start,
  output logic [1:0]  mem_read_write,
  output logic [23:0] mem_address,
  output logic [15:0] mem_data_in
);

  localparam logic [5:0] GUARD_C   = 6'(GUARD);
  localparam logic [5:0] GAP_C     = 6'(GAP);
  localparam logic [5:0] TIMEOUT_C = 6'(TIMEOUT);

  arb_state_t  state, state_nxt;
  logic [5:0]  cnt, cnt_nxt;
  logic        last, last_nxt;
  logic        cur, cur_nxt;
  logic [1:0]  rw_nxt;
  logic [23:0] addr_nxt;
  logic [15:0] wd_nxt, rdata_nxt;
  logic        ack0_nxt, ack1_nxt, err_nxt;
  logic        gnt_valid, gnt_id;

  rr_arb2 u_rr (
    .req       ({req1, req0}),
    .last      (last),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  assign busy           = (state != ST_IDLE);
  assign mem_quad_start = (state == ST_ISSUE);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    last_nxt  = last;
    cur_nxt   = cur;
    rw_nxt    = mem_read_write;
    addr_nxt  = mem_address;
    wd_nxt    = mem_data_in;
    rdata_nxt = rdata;
    ack0_nxt  = 1'b0;
    ack1_nxt  = 1'b0;
    err_nxt   = 1'b0;

    case (state)
      ST_WAIT_INIT: begin
        if (mem_qpi_on) state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (!mem_qpi_on) begin
          state_nxt = ST_WAIT_INIT;
        end else if (gnt_valid) begin
          cur_nxt   = gnt_id;
          last_nxt  = gnt_id;
          rw_nxt    = (gnt_id ? we1 : we0) ? RW_WRITE : RW_READ;
          addr_nxt  = gnt_id ? addr1 : addr0;
          wd_nxt    = gnt_id ? wdata1 : wdata0;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_nxt   = '0;
        state_nxt = ST_BUSY;
      end
      ST_BUSY: begin
        cnt_nxt = cnt + 6'd1;
        // A completion landing on the timeout cycle still counts as success.
        if (cnt >= GUARD_C && mem_endcommand) begin
          ack0_nxt  = ~cur;
          ack1_nxt  = cur;
          if (mem_read_write == RW_READ) rdata_nxt = mem_data_out;
          rw_nxt    = RW_NONE;
          cnt_nxt   = '0;
          state_nxt = ST_GAP;
        end else if (cnt == TIMEOUT_C) begin
          ack0_nxt  = ~cur;
          ack1_nxt  = cur;
          err_nxt   = 1'b1;
          rw_nxt    = RW_NONE;
          cnt_nxt   = '0;
          state_nxt = ST_GAP;
        end
      end
      ST_GAP: begin
        // The ack cycle plus GAP idle cycles keep issues GAP+2 apart from ack.
        if (cnt == GAP_C) state_nxt = ST_IDLE;
        else              cnt_nxt   = cnt + 6'd1;
      end
      default: state_nxt = ST_WAIT_INIT;
    endcase
  end

  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_WAIT_INIT;
      cnt            <= '0;
      last           <= 1'b1;
      cur            <= 1'b0;
      mem_read_write <= RW_NONE;
      mem_address    <= '0;
      mem_data_in    <= '0;
      rdata          <= '0;
      ack0           <= 1'b0;
      ack1           <= 1'b0;
      err            <= 1'b0;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      last           <= last_nxt;
      cur            <= cur_nxt;
      mem_read_write <= rw_nxt;
      mem_address    <= addr_nxt;
      mem_data_in    <= wd_nxt;
      rdata          <= rdata_nxt;
      ack0           <= ack0_nxt;
      ack1           <= ack1_nxt;
      err            <= err_nxt;
    end
  end

endmodule

// File: tb/tb_psram_arbiter.sv
// Self-checking bench for psram_arbiter: a transaction-level model predicts
// grant order, issue/ack cycles, err and rdata; a PSRAM responder drives end.
module tb_psram_arbiter;

  localparam int GUARD   = 3;
  localparam int GAP     = 2;
  localparam int TIMEOUT = 63;

  localparam int M_LAT   = 0;
  localparam int M_HOLD  = 1;
  localparam int M_NEVER = 2;

  logic        mem_clk = 1'b0;
  logic        rst_n;
  logic        req0, req1, we0, we1;
  logic [23:0] addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        ack0, ack1, err, busy;
  logic [15:0] rdata;
  logic        mem_qpi_on, mem_endcommand;
  logic [15:0] mem_data_out;
  logic        mem_quad_start;
  logic [1:0]  mem_read_write;
  logic [23:0] mem_address;
  logic [15:0] mem_data_in;

  psram_arbiter #(.GUARD(GUARD), .GAP(GAP), .TIMEOUT(TIMEOUT)) dut (
    .mem_clk        (mem_clk),
    .rst_n          (rst_n),
    .req0           (req0),
    .req1           (req1),
    .we0            (we0),
    .we1            (we1),
    .addr0          (addr0),
    .addr1          (addr1),
    .wdata0         (wdata0),
    .wdata1         (wdata1),
    .ack0           (ack0),
    .ack1           (ack1),
    .err            (err),
    .rdata          (rdata),
    .busy           (busy),
    .mem_qpi_on     (mem_qpi_on),
    .mem_endcommand (mem_endcommand),
    .mem_data_out   (mem_data_out),
    .mem_quad_start (mem_quad_start),
    .mem_read_write (mem_read_write),
    .mem_address    (mem_address),
    .mem_data_in    (mem_data_in)
  );

  always #5 mem_clk = ~mem_clk;

  int cyc = 0;
  always @(posedge mem_clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  // Requester-side model state.
  bit          pend [2];
  bit          p_we [2];
  logic [23:0] p_addr [2];
  logic [15:0] p_wdata [2];
  bit          model_last = 1'b1;
  logic [15:0] model_rdata = '0;
  int          prev_ack = -1;
  int          last_q = -1;
  int          obs_port = 0;

  // Responder behaviour for the transaction about to issue.
  int          mode = M_LAT;
  int          lat = 5;
  int          early = -1;
  logic [15:0] rval = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic apply_reqs();
    req0 = pend[0]; we0 = p_we[0]; addr0 = p_addr[0]; wdata0 = p_wdata[0];
    req1 = pend[1]; we1 = p_we[1]; addr1 = p_addr[1]; wdata1 = p_wdata[1];
  endtask

  task automatic raise(input int p, input bit we, input logic [23:0] a, input logic [15:0] d);
    pend[p] = 1'b1; p_we[p] = we; p_addr[p] = a; p_wdata[p] = d;
    apply_reqs();
  endtask

  task automatic raise_rand(input int p);
    logic [23:0] a;
    a = 24'($urandom);
    a[23] = p[0];
    raise(p, 1'($urandom_range(0, 1)), a, 16'($urandom));
  endtask

  task automatic pick_resp();
    lat   = $urandom_range(GUARD, 20);
    early = $urandom_range(0, 1) ? int'($urandom_range(0, GUARD - 1)) : -1;
    rval  = 16'($urandom);
  endtask

  // PSRAM responder: counts BUSY cycles from the observed start pulse.
  initial begin
    mem_endcommand = 1'b0;
    mem_data_out   = '0;
    forever begin
      @(negedge mem_clk);
      if (mem_quad_start && rst_n) begin
        for (int k = 0; k <= TIMEOUT + 3; k++) begin
          bit ec, junk;
          if (!rst_n || (k > 0 && (ack0 || ack1))) break;
          junk = (mode == M_LAT) && (k - 1 == early);
          ec = (mode == M_HOLD) || ((mode == M_LAT) && (k - 1 == lat || junk));
          mem_endcommand = ec;
          mem_data_out   = (ec && !junk) ? rval : 16'($urandom);
          @(negedge mem_clk);
        end
        mem_endcommand = 1'b0;
      end
    end
  end

  task automatic run_txn(input string tag);
    int q, exp_p, x, exp_ack;
    bit viol, unstable, is_err;
    logic [1:0]  exp_rw;
    logic [15:0] exp_rd;
    exp_p = (pend[0] && pend[1]) ? (model_last ? 0 : 1) : (pend[1] ? 1 : 0);
    q = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge mem_clk);
      if (mem_quad_start) begin q = cyc; break; end
    end
    check({tag, "_issued"}, 32'(q >= 0), 1);
    if (q < 0) return;
    last_q = q;
    if (prev_ack >= 0) check({tag, "_spacing"}, q - prev_ack, GAP + 2);
    exp_rw = p_we[exp_p] ? 2'd1 : 2'd2;
    check({tag, "_addr"}, mem_address, p_addr[exp_p]);
    check({tag, "_rw"}, mem_read_write, exp_rw);
    check({tag, "_wdata"}, mem_data_in, p_wdata[exp_p]);
    is_err  = (mode == M_NEVER);
    x       = is_err ? TIMEOUT : ((mode == M_HOLD) ? GUARD : lat);
    exp_ack = q + 2 + x;
    viol = 1'b0;
    unstable = 1'b0;
    for (int c = q + 1; c < exp_ack; c++) begin
      @(negedge mem_clk);
      if (ack0 || ack1 || err || mem_quad_start || !busy) viol = 1'b1;
      if (mem_address !== p_addr[exp_p] || mem_read_write !== exp_rw ||
          mem_data_in !== p_wdata[exp_p]) unstable = 1'b1;
    end
    @(negedge mem_clk);
    check({tag, "_early_ack"}, viol, 0);
    check({tag, "_operands_held"}, unstable, 0);
    check({tag, "_ack0"}, ack0, exp_p == 0);
    check({tag, "_ack1"}, ack1, exp_p == 1);
    check({tag, "_err"}, err, is_err);
    obs_port = ack1 ? 1 : 0;
    exp_rd = (!p_we[exp_p] && !is_err) ? rval : model_rdata;
    check({tag, "_rdata"}, rdata, exp_rd);
    model_rdata = exp_rd;
    model_last  = exp_p[0];
    pend[exp_p] = 1'b0;
    apply_reqs();
    @(negedge mem_clk);
    check({tag, "_ack_pulse"}, {ack0, ack1, err}, 0);
    prev_ack = exp_ack;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int  c0, r;
    bit  viol, issued;
    rst_n = 1'b0;
    mem_qpi_on = 1'b0;
    for (int p = 0; p < 2; p++) begin
      pend[p] = 1'b0; p_we[p] = 1'b0; p_addr[p] = '0; p_wdata[p] = '0;
    end
    apply_reqs();
    repeat (3) @(negedge mem_clk);
    check("rst_pulses", {ack0, ack1, err, mem_quad_start}, 0);
    check("rst_rdata", rdata, 0);
    check("rst_addr", mem_address, 0);
    check("rst_data_in", mem_data_in, 0);
    check("rst_rw", mem_read_write, 0);
    check("rst_busy", busy, 1);
    rst_n = 1'b1;

    // Init gating: requests wait until QPI mode is reached.
    raise(0, 1'b0, 24'h000456, 16'h0000);
    viol = 1'b0;
    repeat (100) begin
      @(negedge mem_clk);
      if (mem_quad_start || !busy) viol = 1'b1;
    end
    check("init_hold", viol, 0);
    mem_qpi_on = 1'b1;
    c0 = cyc;
    mode = M_LAT; lat = 5; early = -1; rval = 16'h5A5A;
    run_txn("init");
    check("init_latency", last_q - c0, 2);

    raise(1, 1'b1, 24'h000123, 16'hBEEF);
    mode = M_LAT; lat = 12; early = -1;
    run_txn("write");

    raise(0, 1'b0, 24'hABCDEF, 16'h0000);
    pick_resp();
    rval = 16'h1234;
    early = 0;
    run_txn("read");

    raise(1, 1'b0, 24'h000777, 16'h0000);
    mode = M_HOLD; rval = 16'hC0DE;
    run_txn("guard");

    // Round-robin with both requesters permanently busy.
    raise_rand(0);
    raise_rand(1);
    mode = M_LAT;
    for (int i = 0; i < 4; i++) begin
      pick_resp();
      run_txn("rr");
      check("rr_order", obs_port, i % 2);
      if (i < 3) raise_rand(i % 2);
    end

    mode = M_NEVER;
    run_txn("timeout");
    raise(1, 1'b0, 24'h00BEEF, 16'h0000);
    mode = M_LAT; lat = 7; early = -1; rval = 16'h7777;
    run_txn("post_timeout");

    for (int i = 0; i < 24; i++) begin
      for (int p = 0; p < 2; p++) if (!pend[p] && $urandom_range(0, 1) == 1) raise_rand(p);
      if (!pend[0] && !pend[1]) raise_rand(int'($urandom_range(0, 1)));
      r = $urandom_range(0, 9);
      mode = (r == 0) ? M_NEVER : ((r < 3) ? M_HOLD : M_LAT);
      pick_resp();
      run_txn("rand");
    end
    mode = M_LAT;
    while (pend[0] || pend[1]) begin
      pick_resp();
      run_txn("drain");
    end

    repeat (GAP + 3) @(negedge mem_clk);
    check("idle_busy", busy, 0);

    // Losing QPI while idle blocks a request raised in the same cycle.
    mem_qpi_on = 1'b0;
    raise(0, 1'b1, 24'h0000AA, 16'h5555);
    viol = 1'b0;
    repeat (10) begin
      @(negedge mem_clk);
      if (mem_quad_start || !busy) viol = 1'b1;
    end
    check("qpi_drop_hold", viol, 0);
    mem_qpi_on = 1'b1;
    c0 = cyc;
    prev_ack = -1;
    pick_resp();
    run_txn("requal");
    check("requal_latency", last_q - c0, 2);

    // Reset asserted in the middle of BUSY.
    raise_rand(1);
    mode = M_NEVER;
    issued = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge mem_clk);
      if (mem_quad_start) begin issued = 1'b1; break; end
    end
    check("midrst_issued", issued, 1);
    repeat (4) @(negedge mem_clk);
    rst_n = 1'b0;
    #1;
    check("midrst_pulses", {ack0, ack1, err, mem_quad_start}, 0);
    check("midrst_busy", busy, 1);
    check("midrst_rw", mem_read_write, 0);
    check("midrst_addr", mem_address, 0);
    check("midrst_data_in", mem_data_in, 0);
    check("midrst_rdata", rdata, 0);
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    apply_reqs();
    viol = 1'b0;
    repeat (3) begin
      @(negedge mem_clk);
      if (ack0 || ack1 || err || mem_quad_start) viol = 1'b1;
    end
    check("midrst_no_ack", viol, 0);
    rst_n = 1'b1;
    model_last = 1'b1;
    model_rdata = '0;
    prev_ack = -1;

    raise_rand(0);
    raise_rand(1);
    mode = M_LAT;
    pick_resp();
    run_txn("post_rst");
    check("post_rst_tie", obs_port, 0);
    pick_resp();
    run_txn("post_rst2");
    check("post_rst_next", obs_port, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
